// File: rtl/h_layer_sequencer.sv
// Layered-decoder base-matrix sequencer: stores one circulant shift row per
// layer and streams them layer by layer, iteration after iteration.
module h_layer_sequencer #(
    parameter int SHIFT_W = 8,
    parameter int NCOL    = 35,
    parameter int NLAYER  = 4,
    parameter int ITER_W  = 5,
    localparam int LAYER_W = (NLAYER > 2) ? $clog2(NLAYER) : 1,
    localparam int ROW_W   = SHIFT_W * NCOL
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [LAYER_W-1:0] cfg_addr,
    input  logic [ROW_W-1:0]   cfg_data,
    input  logic               start,
    input  logic [ITER_W-1:0]  max_iter,
    input  logic               restart_iter,
    input  logic               row_ready,
    output logic               row_valid,
    output logic [ROW_W-1:0]   row_data,
    output logic [LAYER_W-1:0] row_layer,
    output logic               row_last,
    output logic               iter_done,
    output logic [ITER_W-1:0]  iter_cnt,
    output logic               busy,
    output logic               done
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NLAYER - 1);
    localparam logic [LAYER_W:0]   NLAYER_X   = (LAYER_W + 1)'(NLAYER);

    logic [0:0]         state;
    logic [ROW_W-1:0]   tbl [NLAYER];
    logic [ITER_W-1:0]  limit;
    logic [ITER_W-1:0]  iter_nxt;
    logic [LAYER_W-1:0] nxt_layer;
    logic               hs;
    logic               at_last;
    logic               cfg_hit;
    logic               start_ok;

    assign hs        = row_valid && row_ready;
    assign at_last   = (row_layer == LAST_LAYER);
    assign nxt_layer = row_layer + 1'b1;
    assign iter_nxt  = iter_cnt + 1'b1;
    assign busy      = (state == S_RUN);

    // Table is frozen while a run is streaming it.
    assign cfg_hit  = (state == S_IDLE) && cfg_we &&
                      ({1'b0, cfg_addr} < NLAYER_X);
    assign start_ok = (state == S_IDLE) && start && !cfg_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NLAYER; i++) begin
                tbl[i] <= '0;
            end
        end else if (cfg_hit) begin
            tbl[cfg_addr] <= cfg_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            limit     <= '0;
            row_valid <= 1'b0;
            row_data  <= '0;
            row_layer <= '0;
            row_last  <= 1'b0;
            iter_done <= 1'b0;
            iter_cnt  <= '0;
            done      <= 1'b0;
        end else begin
            iter_done <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        state     <= S_RUN;
                        iter_cnt  <= '0;
                        limit     <= (max_iter == '0) ? ITER_W'(1) : max_iter;
                        row_valid <= 1'b1;
                        row_layer <= '0;
                        row_data  <= tbl[0];
                        row_last  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (restart_iter) begin
                        row_valid <= 1'b1;
                        row_layer <= '0;
                        row_data  <= tbl[0];
                        row_last  <= 1'b0;
                    end else if (hs) begin
                        if (at_last) begin
                            iter_done <= 1'b1;
                            iter_cnt  <= iter_nxt;
                            row_last  <= 1'b0;
                            if (iter_nxt == limit) begin
                                state     <= S_IDLE;
                                row_valid <= 1'b0;
                                done      <= 1'b1;
                            end else begin
                                row_layer <= '0;
                                row_data  <= tbl[0];
                            end
                        end else begin
                            row_layer <= nxt_layer;
                            row_data  <= tbl[nxt_layer];
                            row_last  <= (nxt_layer == LAST_LAYER);
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    row_valid <= 1'b0;
                    row_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_h_layer_sequencer.sv
// Self-checking bench for h_layer_sequencer: directed scenarios plus a
// randomized run checked against a per-row reference model.
module tb_h_layer_sequencer;

    localparam int SHIFT_W = 8;
    localparam int NCOL    = 35;
    localparam int NLAYER  = 4;
    localparam int ITER_W  = 5;
    localparam int LAYER_W = 2;
    localparam int ROW_W   = SHIFT_W * NCOL;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cfg_we = 1'b0;
    logic [LAYER_W-1:0] cfg_addr = '0;
    logic [ROW_W-1:0]   cfg_data = '0;
    logic               start = 1'b0;
    logic [ITER_W-1:0]  max_iter = '0;
    logic               restart_iter = 1'b0;
    logic               row_ready = 1'b0;
    logic               row_valid;
    logic [ROW_W-1:0]   row_data;
    logic [LAYER_W-1:0] row_layer;
    logic               row_last;
    logic               iter_done;
    logic [ITER_W-1:0]  iter_cnt;
    logic               busy;
    logic               done;

    int checks = 0;
    int failures = 0;
    logic [ROW_W-1:0] mtbl [NLAYER];

    h_layer_sequencer #(
        .SHIFT_W(SHIFT_W),
        .NCOL(NCOL),
        .NLAYER(NLAYER),
        .ITER_W(ITER_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg_we(cfg_we),
        .cfg_addr(cfg_addr),
        .cfg_data(cfg_data),
        .start(start),
        .max_iter(max_iter),
        .restart_iter(restart_iter),
        .row_ready(row_ready),
        .row_valid(row_valid),
        .row_data(row_data),
        .row_layer(row_layer),
        .row_last(row_last),
        .iter_done(iter_done),
        .iter_cnt(iter_cnt),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ROW_W-1:0] rand_row(input int tag);
        logic [ROW_W-1:0] w;
        for (int c = 0; c < NCOL; c++) begin
            w[c*SHIFT_W +: SHIFT_W] = SHIFT_W'($urandom);
        end
        w[ROW_W-1 -: 8] = 8'(tag);
        return w;
    endfunction

    task automatic cfg_write(input int a, input logic [ROW_W-1:0] d);
        cfg_we = 1'b1;
        cfg_addr = LAYER_W'(a);
        cfg_data = d;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic load_table(input int base);
        for (int l = 0; l < NLAYER; l++) begin
            mtbl[l] = rand_row(base + l);
            cfg_write(l, mtbl[l]);
        end
    endtask

    task automatic do_start(input int mi);
        start = 1'b1;
        max_iter = ITER_W'(mi);
        step();
        start = 1'b0;
    endtask

    task automatic wait_idle(output int pulses);
        int n;
        n = 0;
        pulses = 0;
        while (busy && n < 300) begin
            step();
            n++;
            if (iter_done) pulses++;
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
        end
    endtask

    task automatic test_reset();
        int p;
        rst_n = 1'b0;
        #3;
        checks++;
        if ({row_valid, row_data, row_layer, row_last, iter_done, iter_cnt, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b layer=%0d cnt=%0d busy=%b done=%b, required all 0",
                     row_valid, row_layer, iter_cnt, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        row_ready = 1'b1;
        do_start(1);
        checks++;
        if ({row_valid, busy, row_layer} !== {1'b1, 1'b1, 2'd0} || row_data !== '0) begin
            failures++;
            $display("FAIL first_start: valid=%b busy=%b layer=%0d data=%h, required 1 1 0 zero",
                     row_valid, busy, row_layer, row_data);
        end
        wait_idle(p);
    endtask

    task automatic test_basic();
        int p;
        load_table(1);
        row_ready = 1'b1;
        do_start(2);
        for (int t = 1; t <= 8; t++) begin
            checks++;
            if ({row_valid, row_layer, row_last, iter_done, done} !==
                {1'b1, 2'((t - 1) % 4), ((t - 1) % 4) == 3, t == 5, 1'b0} ||
                row_data !== mtbl[(t - 1) % 4]) begin
                failures++;
                $display("FAIL basic_c%0d: v=%b l=%0d last=%b id=%b d=%b, required v=1 l=%0d",
                         t, row_valid, row_layer, row_last, iter_done, done, (t - 1) % 4);
            end
            step();
        end
        checks++;
        if ({row_valid, iter_done, done, busy, iter_cnt} !== {1'b0, 1'b1, 1'b1, 1'b0, 5'd2}) begin
            failures++;
            $display("FAIL basic_end: v=%b id=%b done=%b busy=%b cnt=%0d, required 0 1 1 0 2",
                     row_valid, iter_done, done, busy, iter_cnt);
        end
        step();
        checks++;
        if ({done, iter_done, iter_cnt} !== {1'b0, 1'b0, 5'd2}) begin
            failures++;
            $display("FAIL basic_hold: done=%b id=%b cnt=%0d, required 0 0 2", done, iter_done, iter_cnt);
        end
        wait_idle(p);
    endtask

    task automatic test_stall();
        int p;
        row_ready = 1'b1;
        do_start(1);
        step();
        row_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({row_valid, row_layer} !== {1'b1, 2'd1} || row_data !== mtbl[1]) begin
                failures++;
                $display("FAIL stall_hold%0d: v=%b l=%0d, required 1 1", i, row_valid, row_layer);
            end
            if (i == 2) row_ready = 1'b1;
            step();
        end
        checks++;
        if ({row_valid, row_layer} !== {1'b1, 2'd2} || row_data !== mtbl[2]) begin
            failures++;
            $display("FAIL stall_release: v=%b l=%0d, required 1 2", row_valid, row_layer);
        end
        wait_idle(p);
    endtask

    task automatic test_restart();
        int p;
        row_ready = 1'b1;
        do_start(3);
        step();
        step();
        checks++;
        if (row_layer !== 2'd2) begin
            failures++;
            $display("FAIL restart_pre: l=%0d, required 2", row_layer);
        end
        restart_iter = 1'b1;
        step();
        restart_iter = 1'b0;
        checks++;
        if ({row_valid, row_layer, iter_done, iter_cnt} !== {1'b1, 2'd0, 1'b0, 5'd0} ||
            row_data !== mtbl[0]) begin
            failures++;
            $display("FAIL restart_l0: v=%b l=%0d id=%b cnt=%0d, required 1 0 0 0",
                     row_valid, row_layer, iter_done, iter_cnt);
        end
        wait_idle(p);
        checks++;
        if (p !== 3 || iter_cnt !== 5'd3) begin
            failures++;
            $display("FAIL restart_total: pulses=%0d cnt=%0d, required 3 3", p, iter_cnt);
        end
    endtask

    task automatic test_cfg_run();
        int p;
        logic [ROW_W-1:0] newd;
        newd = rand_row(99);
        row_ready = 1'b1;
        do_start(2);
        cfg_we = 1'b1;
        cfg_addr = 2'd1;
        cfg_data = newd;
        step();
        cfg_we = 1'b0;
        for (int i = 0; i < 4; i++) step();
        checks++;
        if (row_layer !== 2'd1 || row_data !== mtbl[1]) begin
            failures++;
            $display("FAIL cfg_run_ignored: l=%0d data=%h, required 1 %h", row_layer, row_data, mtbl[1]);
        end
        wait_idle(p);
        cfg_we = 1'b1;
        cfg_addr = 2'd1;
        cfg_data = newd;
        start = 1'b1;
        max_iter = 5'd1;
        step();
        cfg_we = 1'b0;
        start = 1'b0;
        mtbl[1] = newd;
        step();
        checks++;
        if ({busy, row_valid} !== 2'b00) begin
            failures++;
            $display("FAIL cfg_start_drop: busy=%b v=%b, required 0 0", busy, row_valid);
        end
        do_start(1);
        step();
        checks++;
        if (row_layer !== 2'd1 || row_data !== newd) begin
            failures++;
            $display("FAIL cfg_idle_write: l=%0d data=%h, required 1 %h", row_layer, row_data, newd);
        end
        wait_idle(p);
    endtask

    task automatic test_zero_iter();
        int p;
        row_ready = 1'b1;
        do_start(0);
        for (int i = 0; i < 4; i++) step();
        checks++;
        if ({row_valid, done, iter_done, iter_cnt, busy} !== {1'b0, 1'b1, 1'b1, 5'd1, 1'b0}) begin
            failures++;
            $display("FAIL zero_iter: v=%b done=%b id=%b cnt=%0d busy=%b, required 0 1 1 1 0",
                     row_valid, done, iter_done, iter_cnt, busy);
        end
        wait_idle(p);
    endtask

    task automatic test_reset_midrun();
        int p;
        row_ready = 1'b1;
        do_start(5);
        step();
        step();
        checks++;
        if (row_layer !== 2'd2) begin
            failures++;
            $display("FAIL midrun_pre: l=%0d, required 2", row_layer);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({row_valid, row_data, row_layer, row_last, iter_done, iter_cnt, busy, done} !== '0) begin
            failures++;
            $display("FAIL midrun_reset: v=%b l=%0d cnt=%0d busy=%b, required all 0",
                     row_valid, row_layer, iter_cnt, busy);
        end
        for (int l = 0; l < NLAYER; l++) mtbl[l] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        do_start(1);
        for (int l = 0; l < NLAYER; l++) begin
            checks++;
            if ({row_valid, row_layer} !== {1'b1, 2'(l)} || row_data !== '0) begin
                failures++;
                $display("FAIL midrun_zero_tbl%0d: v=%b l=%0d data=%h, required 1 %0d zero",
                         l, row_valid, row_layer, row_data, l);
            end
            step();
        end
        wait_idle(p);
    endtask

    task automatic test_random();
        int  l, cnt, lim, n;
        bit  mv, ed, edn, rdy, rs;
        load_table(20);
        for (int r = 0; r < 25; r++) begin
            lim = $urandom_range(0, 3);
            row_ready = 1'b1;
            do_start(lim);
            if (lim == 0) lim = 1;
            mv = 1; l = 0; cnt = 0; ed = 0; edn = 0; n = 0;
            while ((mv || edn) && n < 400) begin
                checks++;
                if ({row_valid, iter_done, done, busy, iter_cnt} !== {mv, ed, edn, mv, 5'(cnt)} ||
                    (mv && ({row_layer, row_last} !== {2'(l), l == NLAYER - 1} || row_data !== mtbl[l]))) begin
                    failures++;
                    $display("FAIL rand_r%0d_c%0d: v=%b id=%b d=%b cnt=%0d l=%0d, required v=%b id=%b d=%b cnt=%0d l=%0d",
                             r, n, row_valid, iter_done, done, iter_cnt, row_layer, mv, ed, edn, cnt, l);
                end
                if (!mv) break;
                rdy = ($urandom_range(0, 9) < 7);
                rs = ($urandom_range(0, 19) == 0);
                row_ready = rdy;
                restart_iter = rs;
                ed = 0;
                edn = 0;
                if (rs) begin
                    l = 0;
                end else if (rdy) begin
                    if (l == NLAYER - 1) begin
                        ed = 1;
                        cnt = (cnt + 1) % 32;
                        if (cnt == lim) begin
                            mv = 0;
                            edn = 1;
                        end else begin
                            l = 0;
                        end
                    end else begin
                        l++;
                    end
                end
                step();
                restart_iter = 1'b0;
                n++;
            end
            checks++;
            if (n >= 400 || busy !== 1'b0) begin
                failures++;
                $display("FAIL rand_r%0d_end: busy=%b cycles=%0d, required 0", r, busy, n);
            end
            step();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int l = 0; l < NLAYER; l++) mtbl[l] = '0;
        test_reset();
        test_basic();
        test_stall();
        test_restart();
        test_cfg_run();
        test_zero_iter();
        test_reset_midrun();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
